// File: rtl/led_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : led_stream_decoder
// Purpose  : Watches a one-hot running-light LED bus and decodes it back into
//            position, direction, step pulses and stall status. It flags
//            illegal patterns and non-adjacent jumps.
// Ports    : CLK        - system clock (rising edge)
//            Reset      - synchronous, active-high reset
//            LED_in     - LED vector under observation
//            Pos        - index of the lit LED
//            Pos_valid  - Pos holds a legal one-hot decode
//            Dir        - last step direction (1 = toward higher index)
//            Step       - one-cycle pulse per legal adjacent move
//            Stopped    - pattern unchanged for >= STALL_LIMIT samples
//            Error      - one-cycle pulse on an illegal pattern or jump
//            Fault      - sticky error flag, cleared only by Reset
//            Step_count - wrapping count of Step pulses
// Config   : LED_DECODER_STEP_COUNT_EN builds the 16-bit step counter.
//            When it is undefined, Step_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module led_stream_decoder #(
    parameter int WIDTH       = 16,
    parameter int STALL_LIMIT = 1024
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic [WIDTH-1:0]         LED_in,
    output logic [$clog2(WIDTH)-1:0] Pos,
    output logic                     Pos_valid,
    output logic                     Dir,
    output logic                     Step,
    output logic                     Stopped,
    output logic                     Error,
    output logic                     Fault,
    output logic [15:0]              Step_count
);

    localparam int PW = $clog2(WIDTH);
    localparam int CW = $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TRACK   = 2'd1,
        S_STALLED = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    // Ors together the indices of set bits; exact for a one-hot input.
    function automatic logic [PW-1:0] encode(input logic [WIDTH-1:0] v);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) r = r | PW'(i);
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cur_q, prev_q;
    logic [PW-1:0]    pos_q, pos_d;
    logic             pos_valid_q, pos_valid_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             stopped_q, stopped_d;
    logic             error_q, error_d;
    logic             fault_q, fault_d;
    logic [CW-1:0]    stall_q, stall_d;

    logic             cur_legal, prev_legal;
    logic [PW-1:0]    cur_pos, prev_pos;
    logic             is_same, is_up, is_down;

    // Power-of-two WIDTH makes the PW-bit add/subtract wrap exactly mod WIDTH.
    always_comb begin
        cur_legal  = is_onehot(cur_q);
        prev_legal = is_onehot(prev_q);
        cur_pos    = encode(cur_q);
        prev_pos   = encode(prev_q);
        is_same    = (cur_q == prev_q);
        is_up      = (cur_pos == prev_pos + PW'(1));
        is_down    = (cur_pos == prev_pos - PW'(1));
    end

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        pos_valid_d = pos_valid_q;
        dir_d       = dir_q;
        step_d      = 1'b0;
        stopped_d   = stopped_q;
        error_d     = 1'b0;
        fault_d     = fault_q;
        stall_d     = stall_q;

        case (state_q)
            S_IDLE: begin
                // Illegal samples here are the bus still settling: ignored.
                if (cur_legal) begin
                    pos_d       = cur_pos;
                    pos_valid_d = 1'b1;
                    state_d     = S_TRACK;
                end
            end
            S_TRACK, S_STALLED: begin
                if (!cur_legal) begin
                    error_d     = 1'b1;
                    fault_d     = 1'b1;
                    pos_valid_d = 1'b0;
                    state_d     = S_FAULT;
                end else begin
                    pos_d       = cur_pos;
                    pos_valid_d = 1'b1;
                    if (is_same) begin
                        if (stall_q >= LIMIT - CW'(1)) begin
                            stall_d   = LIMIT;
                            stopped_d = 1'b1;
                            state_d   = S_STALLED;
                        end else begin
                            stall_d = stall_q + CW'(1);
                        end
                    end else if (is_up || is_down) begin
                        step_d    = 1'b1;
                        dir_d     = is_up;
                        stall_d   = '0;
                        stopped_d = 1'b0;
                        state_d   = S_TRACK;
                    end else begin
                        error_d = 1'b1;
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end
                end
            end
            S_FAULT: begin
                // Position keeps tracking; steps and stall logic are frozen.
                if (!cur_legal) begin
                    error_d     = 1'b1;
                    pos_valid_d = 1'b0;
                end else begin
                    pos_d       = cur_pos;
                    pos_valid_d = 1'b1;
                    // A jump is only judged against a legal previous sample.
                    if (prev_legal && !is_same && !is_up && !is_down) begin
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cur_q       <= '0;
            prev_q      <= '0;
            state_q     <= S_IDLE;
            pos_q       <= '0;
            pos_valid_q <= 1'b0;
            dir_q       <= 1'b1;
            step_q      <= 1'b0;
            stopped_q   <= 1'b0;
            error_q     <= 1'b0;
            fault_q     <= 1'b0;
            stall_q     <= '0;
        end else begin
            cur_q       <= LED_in;
            prev_q      <= cur_q;
            state_q     <= state_d;
            pos_q       <= pos_d;
            pos_valid_q <= pos_valid_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            stopped_q   <= stopped_d;
            error_q     <= error_d;
            fault_q     <= fault_d;
            stall_q     <= stall_d;
        end
    end

`ifdef LED_DECODER_STEP_COUNT_EN
    logic [15:0] step_count_q;

    // Counts on the same edge that registers Step, so the two agree.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            step_count_q <= '0;
        end else if (step_d) begin
            step_count_q <= step_count_q + 16'd1;
        end
    end

    assign Step_count = step_count_q;
`else
    assign Step_count = '0;
`endif

    assign Pos       = pos_q;
    assign Pos_valid = pos_valid_q;
    assign Dir       = dir_q;
    assign Step      = step_q;
    assign Stopped   = stopped_q;
    assign Error     = error_q;
    assign Fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_led_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_stream_decoder
// Purpose  : Self-checking bench for led_stream_decoder. A sample-history
//            model predicts every output each cycle; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_stream_decoder;

    localparam int W     = 16;
    localparam int LIMIT = 8;
`ifdef LED_DECODER_STEP_COUNT_EN
    localparam int EXP_SC_WALK = 16;
`else
    localparam int EXP_SC_WALK = 0;
`endif

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] LED_in = 16'h0040;
    logic [3:0]  Pos;
    logic        Pos_valid, Dir, Step, Stopped, Error, Fault;
    logic [15:0] Step_count;

    int total = 0;
    int bad = 0;
    int seen_steps = 0;
    int seen_errs = 0;

    led_stream_decoder #(.WIDTH(W), .STALL_LIMIT(LIMIT)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .LED_in     (LED_in),
        .Pos        (Pos),
        .Pos_valid  (Pos_valid),
        .Dir        (Dir),
        .Step       (Step),
        .Stopped    (Stopped),
        .Error      (Error),
        .Fault      (Fault),
        .Step_count (Step_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx(input logic [15:0] v);
        for (int i = 0; i < W; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Model: h1/h2 are the two most recent LED samples (the DUT's cur/prev).
    // mode 0 = waiting for first legal sample, 1 = tracking, 2 = faulted.
    int          m_mode = 0;
    int          m_pos = 0, m_cnt = 0, m_sc = 0;
    bit          m_pv = 0, m_dir = 1, m_step = 0, m_stop = 0, m_err = 0, m_fault = 0;
    logic [15:0] h1 = '0, h2 = '0;
    bit          cl, pl;
    int          cp, pp, d;

    always @(posedge CLK) begin
        if (Reset) begin
            m_mode = 0; m_pos = 0; m_cnt = 0; m_sc = 0;
            m_pv = 0; m_dir = 1; m_step = 0; m_stop = 0; m_err = 0; m_fault = 0;
            h1 = '0; h2 = '0;
        end else begin
            m_step = 0; m_err = 0;
            cl = ($countones(h1) == 1);
            pl = ($countones(h2) == 1);
            cp = idx(h1);
            pp = idx(h2);
            d  = (cp - pp + W) % W;
            if (m_mode == 0) begin
                if (cl) begin m_pos = cp; m_pv = 1; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (!cl) begin
                    m_err = 1; m_fault = 1; m_pv = 0; m_mode = 2;
                end else begin
                    m_pos = cp; m_pv = 1;
                    if (d == 0) begin
                        if (m_cnt < LIMIT) m_cnt++;
                        if (m_cnt == LIMIT) m_stop = 1;
                    end else if (d == 1 || d == W - 1) begin
                        m_step = 1; m_dir = (d == 1); m_cnt = 0; m_stop = 0;
                    end else begin
                        m_err = 1; m_fault = 1; m_mode = 2;
                    end
                end
            end else begin
                if (!cl) begin
                    m_err = 1; m_pv = 0;
                end else begin
                    m_pos = cp; m_pv = 1;
                    if (pl && d != 0 && d != 1 && d != W - 1) m_err = 1;
                end
            end
`ifdef LED_DECODER_STEP_COUNT_EN
            if (m_step) m_sc = (m_sc + 1) % 65536;
`endif
            h2 = h1;
            h1 = LED_in;
        end
        #1;
        chk("cyc Pos",        int'(Pos),        m_pos);
        chk("cyc Pos_valid",  int'(Pos_valid),  int'(m_pv));
        chk("cyc Dir",        int'(Dir),        int'(m_dir));
        chk("cyc Step",       int'(Step),       int'(m_step));
        chk("cyc Stopped",    int'(Stopped),    int'(m_stop));
        chk("cyc Error",      int'(Error),      int'(m_err));
        chk("cyc Fault",      int'(Fault),      int'(m_fault));
        chk("cyc Step_count", int'(Step_count), m_sc);
        if (Step)  seen_steps++;
        if (Error) seen_errs++;
    end

    // Two reset edges with v on the bus; returns at a negedge with Reset low.
    task automatic do_reset(input logic [15:0] v);
        @(negedge CLK);
        Reset  = 1'b1;
        LED_in = v;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst Pos_valid",  int'(Pos_valid),  0);
        chk("rst Fault",      int'(Fault),      0);
        chk("rst Dir",        int'(Dir),        1);
        chk("rst Step_count", int'(Step_count), 0);
        Reset = 1'b0;
    endtask

    initial begin
        // Reset values and first decode
        do_reset(16'h0040);
        chk("rst Pos", int'(Pos), 0);
        @(negedge CLK);
        chk("first pv early", int'(Pos_valid), 0);
        @(negedge CLK);
        chk("first pv", int'(Pos_valid), 1);
        chk("first Pos", int'(Pos), 6);
        chk("first Step", int'(Step), 0);

        // Forward walk with wrap 15 -> 0
        do_reset(16'h0001);
        repeat (3) @(negedge CLK);
        seen_steps = 0;
        for (int i = 1; i <= 16; i++) begin
            LED_in = 16'(32'h1 << (i % 16));
            @(negedge CLK);
        end
        repeat (2) @(negedge CLK);
        chk("walk steps", seen_steps, 16);
        chk("walk Dir", int'(Dir), 1);
        chk("walk Pos", int'(Pos), 0);
        chk("walk Step_count", int'(Step_count), EXP_SC_WALK);

        // Reverse with wrap 0 -> 15 -> 14
        do_reset(16'h0001);
        repeat (3) @(negedge CLK);
        seen_steps = 0;
        seen_errs  = 0;
        LED_in = 16'h8000;
        @(negedge CLK);
        LED_in = 16'h4000;
        repeat (3) @(negedge CLK);
        chk("rev steps", seen_steps, 2);
        chk("rev Dir", int'(Dir), 0);
        chk("rev Pos", int'(Pos), 14);
        chk("rev errs", seen_errs, 0);

        // Stall: Stopped on the 8th equal comparison (edge 10 after release)
        do_reset(16'h0010);
        repeat (9) @(negedge CLK);
        chk("stall pre", int'(Stopped), 0);
        @(negedge CLK);
        chk("stall rise", int'(Stopped), 1);
        LED_in = 16'h0020;
        @(negedge CLK);
        chk("stall hold", int'(Stopped), 1);
        @(negedge CLK);
        chk("stall step", int'(Step), 1);
        chk("stall clear", int'(Stopped), 0);

        // Illegal jump 3 -> 7, then legal shifts give no Step
        do_reset(16'h0008);
        repeat (3) @(negedge CLK);
        seen_steps = 0;
        seen_errs  = 0;
        LED_in = 16'h0080;
        repeat (2) @(negedge CLK);
        chk("jump Error", int'(Error), 1);
        chk("jump Fault", int'(Fault), 1);
        chk("jump Pos", int'(Pos), 7);
        chk("jump Step", int'(Step), 0);
        @(negedge CLK);
        chk("jump Error pulse", int'(Error), 0);
        LED_in = 16'h0100;
        @(negedge CLK);
        LED_in = 16'h0200;
        repeat (3) @(negedge CLK);
        chk("fault steps", seen_steps, 0);
        chk("fault errs", seen_errs, 1);
        chk("fault Pos", int'(Pos), 9);
        chk("fault sticky", int'(Fault), 1);

        // Illegal pattern, then reset mid-operation
        do_reset(16'h0001);
        repeat (3) @(negedge CLK);
        LED_in = 16'h0002;
        @(negedge CLK);
        LED_in = 16'h0004;
        @(negedge CLK);
        LED_in = 16'h0011;
        repeat (2) @(negedge CLK);
        chk("illegal Error", int'(Error), 1);
        chk("illegal pv", int'(Pos_valid), 0);
        chk("illegal Fault", int'(Fault), 1);
        LED_in = 16'h0008;
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        chk("midrst Fault", int'(Fault), 0);
        chk("midrst pv", int'(Pos_valid), 0);
        chk("midrst Step_count", int'(Step_count), 0);
        repeat (2) @(negedge CLK);
        chk("midrst relock pv", int'(Pos_valid), 1);
        chk("midrst relock Pos", int'(Pos), 3);
        chk("midrst relock Error", int'(Error), 0);
        chk("midrst relock Fault", int'(Fault), 0);

        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
